// File: rtl/speccy_matrix_to_scancode_if.sv
// Keyboard event bus shared by the matrix scanner and its PS/2-side consumers.
//   scan_received : one-cycle event strobe
//   scan[6:0]     : PS/2 set-2 scancode (low 7 bits)
//   extended      : code carries the E0 prefix
//   released      : 1 = break, 0 = make
// master = event producer, slave = event consumer.
interface speccy_matrix_to_scancode_if;
    logic       scan_received;
    logic [6:0] scan;
    logic       extended;
    logic       released;

    modport master (
        output scan_received,
        output scan,
        output extended,
        output released
    );

    modport slave (
        input scan_received,
        input scan,
        input extended,
        input released
    );
endinterface

// File: rtl/speccy_matrix_to_scancode.sv
// Scans a 40-key Spectrum matrix (active-low, bit = row*5 + col) and emits
// PS/2 set-2 make/break events on the shared keyboard event bus.
//   clk, rst : system clock, asynchronous active-high reset
//   enable   : 1 = scanning allowed, 0 = park in IDLE
//   flush    : one-cycle pulse, break every key recorded as pressed
//   matrix   : live key state, 0 = pressed (synchronous to clk)
//   ev       : event bus (scan_received, scan, extended, released)
//   busy     : high whenever the scanner is not IDLE
module speccy_matrix_to_scancode #(
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        flush,
    input  logic [39:0] matrix,
    speccy_matrix_to_scancode_if.master ev,
    output logic        busy
);
    localparam int unsigned NUM_KEYS = 40;
    localparam int unsigned IDX_W    = 6;
    localparam int unsigned GAP_W    = 8;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_KEYS - 1);
    localparam logic [IDX_W-1:0] SYM_IDX   = IDX_W'(36);
    localparam logic [IDX_W-1:0] PASS_FULL = IDX_W'(NUM_KEYS);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, GAP} state_t;

    state_t               state;
    logic [IDX_W-1:0]     idx;
    logic [NUM_KEYS-1:0]  prev;
    logic                 flush_pend;
    logic [IDX_W-1:0]     pass_cnt;
    logic [GAP_W-1:0]     gap_cnt;

    logic                 tgt;
    logic                 wrap;
    logic [IDX_W-1:0]     idx_inc;
    logic [IDX_W-1:0]     pass_inc;
    logic                 pass_done;

    // Set-2 code for each matrix position, SYMBOL SHIFT maps to (E0) 14.
    function automatic logic [6:0] key_code(input logic [IDX_W-1:0] i);
        case (i)
            6'd0:  key_code = 7'h12;  6'd1:  key_code = 7'h1A;
            6'd2:  key_code = 7'h22;  6'd3:  key_code = 7'h21;
            6'd4:  key_code = 7'h2A;  6'd5:  key_code = 7'h1C;
            6'd6:  key_code = 7'h1B;  6'd7:  key_code = 7'h23;
            6'd8:  key_code = 7'h2B;  6'd9:  key_code = 7'h34;
            6'd10: key_code = 7'h15;  6'd11: key_code = 7'h1D;
            6'd12: key_code = 7'h24;  6'd13: key_code = 7'h2D;
            6'd14: key_code = 7'h2C;  6'd15: key_code = 7'h16;
            6'd16: key_code = 7'h1E;  6'd17: key_code = 7'h26;
            6'd18: key_code = 7'h25;  6'd19: key_code = 7'h2E;
            6'd20: key_code = 7'h45;  6'd21: key_code = 7'h46;
            6'd22: key_code = 7'h3E;  6'd23: key_code = 7'h3D;
            6'd24: key_code = 7'h36;  6'd25: key_code = 7'h4D;
            6'd26: key_code = 7'h44;  6'd27: key_code = 7'h43;
            6'd28: key_code = 7'h3C;  6'd29: key_code = 7'h35;
            6'd30: key_code = 7'h5A;  6'd31: key_code = 7'h4B;
            6'd32: key_code = 7'h42;  6'd33: key_code = 7'h3B;
            6'd34: key_code = 7'h33;  6'd35: key_code = 7'h29;
            6'd36: key_code = 7'h14;  6'd37: key_code = 7'h3A;
            6'd38: key_code = 7'h31;  6'd39: key_code = 7'h32;
            default: key_code = 7'h00;
        endcase
    endfunction

    // Index advance and flush-pass bookkeeping. pass_cnt saturates at 40, so
    // the flush pass ends on the first wrap after a complete 40-index sweep.
    always_comb begin
        tgt       = flush_pend ? 1'b1 : matrix[idx];
        wrap      = (idx == LAST_IDX);
        idx_inc   = wrap ? '0 : idx + IDX_W'(1);
        pass_inc  = (pass_cnt == PASS_FULL) ? pass_cnt : pass_cnt + IDX_W'(1);
        pass_done = wrap && (pass_inc == PASS_FULL);
    end

    // Scanner FSM with registered event outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            idx              <= '0;
            prev             <= '1;
            flush_pend       <= 1'b0;
            pass_cnt         <= '0;
            gap_cnt          <= '0;
            busy             <= 1'b0;
            ev.scan_received <= 1'b0;
            ev.scan          <= '0;
            ev.extended      <= 1'b0;
            ev.released      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable || flush_pend) begin
                        state <= SCAN;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (tgt != prev[idx]) begin
                        ev.scan          <= key_code(idx);
                        ev.extended      <= (idx == SYM_IDX);
                        ev.released      <= tgt;
                        ev.scan_received <= 1'b1;
                        prev[idx]        <= tgt;
                        state            <= EMIT;
                    end else begin
                        idx <= idx_inc;
                        if (flush_pend) begin
                            pass_cnt <= pass_inc;
                            if (pass_done) flush_pend <= 1'b0;
                        end
                        if (wrap && !enable) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                EMIT: begin
                    ev.scan_received <= 1'b0;
                    idx              <= idx_inc;
                    if (flush_pend) begin
                        pass_cnt <= pass_inc;
                        if (pass_done) flush_pend <= 1'b0;
                    end
                    gap_cnt <= GAP_W'(GAP_CYCLES);
                    state   <= GAP;
                end
                GAP: begin
                    if (gap_cnt <= GAP_W'(1)) begin
                        if (!enable && !flush_pend) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= SCAN;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            // A new flush request (re)starts the flush pass.
            if (flush) begin
                flush_pend <= 1'b1;
                pass_cnt   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_speccy_matrix_to_scancode.sv
// Self-checking bench for speccy_matrix_to_scancode: a table of single-key
// make/break vectors plus hand-written ordering, flush, enable and reset
// sequences. Outputs are sampled on the falling clock edge.
module tb_speccy_matrix_to_scancode;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        flush;
    logic [39:0] matrix;
    logic        busy;

    speccy_matrix_to_scancode_if bus ();

    speccy_matrix_to_scancode #(.GAP_CYCLES(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .flush  (flush),
        .matrix (matrix),
        .ev     (bus),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] scan;
        logic       ext;
        logic       rel;
        int         cyc;
    } ev_t;

    typedef struct {
        int         bit_idx;
        logic       val;
        logic [6:0] scan;
        logic       ext;
        logic       rel;
    } vec_t;

    ev_t  evq[$];
    vec_t vecs[10];
    int   cyc;
    int   total;
    int   bad;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // One clock; sample at the falling edge and record any strobe.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (bus.scan_received)
            evq.push_back('{bus.scan, bus.extended, bus.released, cyc});
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Wait until n events are queued, bounded by max cycles.
    task automatic wait_ev(input string name, input int n, input int max);
        int k;
        k = 0;
        while (evq.size() < n && k < max) begin
            step();
            k++;
        end
        if (evq.size() < n) check({name, "_timeout"}, evq.size(), n);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        cyc    = 0;
        rst    = 1'b1;
        enable = 1'b0;
        flush  = 1'b0;
        matrix = '1;

        vecs[0] = '{13, 1'b0, 7'h2D, 1'b0, 1'b0};
        vecs[1] = '{13, 1'b1, 7'h2D, 1'b0, 1'b1};
        vecs[2] = '{36, 1'b0, 7'h14, 1'b1, 1'b0};
        vecs[3] = '{36, 1'b1, 7'h14, 1'b1, 1'b1};
        vecs[4] = '{0,  1'b0, 7'h12, 1'b0, 1'b0};
        vecs[5] = '{0,  1'b1, 7'h12, 1'b0, 1'b1};
        vecs[6] = '{39, 1'b0, 7'h32, 1'b0, 1'b0};
        vecs[7] = '{39, 1'b1, 7'h32, 1'b0, 1'b1};
        vecs[8] = '{24, 1'b0, 7'h36, 1'b0, 1'b0};
        vecs[9] = '{24, 1'b1, 7'h36, 1'b0, 1'b1};

        // Reset state.
        run(3);
        check("rst_strobe",   int'(bus.scan_received), 0);
        check("rst_scan",     int'(bus.scan), 0);
        check("rst_extended", int'(bus.extended), 0);
        check("rst_released", int'(bus.released), 0);
        check("rst_busy",     int'(busy), 0);
        rst = 1'b0;

        // Idle matrix with scanning enabled: no events.
        enable = 1'b1;
        run(100);
        check("idle_no_events", evq.size(), 0);
        check("busy_enabled", int'(busy), 1);

        // Single-key make/break table.
        foreach (vecs[i]) begin
            evq.delete();
            matrix[vecs[i].bit_idx] = vecs[i].val;
            wait_ev($sformatf("vec%0d", i), 1, 200);
            run(100);
            check($sformatf("vec%0d_count", i), evq.size(), 1);
            if (evq.size() >= 1) begin
                check($sformatf("vec%0d_scan", i), int'(evq[0].scan), int'(vecs[i].scan));
                check($sformatf("vec%0d_ext", i),  int'(evq[0].ext),  int'(vecs[i].ext));
                check($sformatf("vec%0d_rel", i),  int'(evq[0].rel),  int'(vecs[i].rel));
            end
            check($sformatf("vec%0d_hold", i), int'(bus.scan), int'(vecs[i].scan));
        end

        // Simultaneous change with idx parked at 39: B before CS, 10 clocks apart.
        evq.delete();
        matrix[38] = 1'b0;
        wait_ev("sim1_k38", 1, 200);
        matrix[0]  = 1'b0;
        matrix[39] = 1'b0;
        wait_ev("sim1", 3, 200);
        run(60);
        check("sim1_count", evq.size(), 3);
        if (evq.size() >= 3) begin
            check("sim1_first",   int'(evq[1].scan), 'h32);
            check("sim1_second",  int'(evq[2].scan), 'h12);
            check("sim1_spacing", evq[2].cyc - evq[1].cyc, 10);
        end

        // Simultaneous change with idx parked at 0: CS break before B make.
        matrix[38] = 1'b1;
        run(120);
        evq.delete();
        matrix[39] = 1'b1;
        wait_ev("sim2_k39", 1, 200);
        matrix[0]  = 1'b1;
        matrix[39] = 1'b0;
        wait_ev("sim2", 3, 200);
        run(60);
        check("sim2_count", evq.size(), 3);
        if (evq.size() >= 3) begin
            check("sim2_first_scan", int'(evq[1].scan), 'h12);
            check("sim2_first_rel",  int'(evq[1].rel), 1);
            check("sim2_second",     int'(evq[2].scan), 'h32);
            check("sim2_spacing",    evq[2].cyc - evq[1].cyc, 48);
        end
        matrix[39] = 1'b1;
        run(120);

        // Flush with A, 0 and ENTER held; flush issued as A's make strobes.
        evq.delete();
        matrix[30] = 1'b0;
        wait_ev("fl_m30", 1, 200);
        matrix[20] = 1'b0;
        wait_ev("fl_m20", 2, 200);
        matrix[5] = 1'b0;
        wait_ev("fl_m5", 3, 200);
        evq.delete();
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_ev("flush", 6, 600);
        run(100);
        check("flush_count", evq.size(), 6);
        if (evq.size() >= 6) begin
            check("flush_b0", int'(evq[0].scan), 'h45);
            check("flush_b1", int'(evq[1].scan), 'h5A);
            check("flush_b2", int'(evq[2].scan), 'h1C);
            check("flush_brel", int'(evq[0].rel & evq[1].rel & evq[2].rel), 1);
            check("flush_m0", int'(evq[3].scan), 'h1C);
            check("flush_m1", int'(evq[4].scan), 'h45);
            check("flush_m2", int'(evq[5].scan), 'h5A);
            check("flush_mrel", int'(evq[3].rel | evq[4].rel | evq[5].rel), 0);
        end
        matrix = '1;
        run(200);

        // Disabled scanner parks and ignores the matrix until re-enabled.
        enable = 1'b0;
        run(100);
        check("dis_busy", int'(busy), 0);
        evq.delete();
        matrix[7] = 1'b0;
        run(100);
        check("dis_no_events", evq.size(), 0);
        enable = 1'b1;
        wait_ev("reen", 1, 200);
        if (evq.size() >= 1) check("reen_scan", int'(evq[0].scan), 'h23);
        matrix[7] = 1'b1;
        run(120);

        // Reset during GAP clears outputs at once; held key is made again.
        evq.delete();
        matrix[13] = 1'b0;
        wait_ev("rg_make", 1, 200);
        run(3);
        rst = 1'b1;
        #1;
        check("rg_scan",     int'(bus.scan), 0);
        check("rg_strobe",   int'(bus.scan_received), 0);
        check("rg_released", int'(bus.released), 0);
        check("rg_busy",     int'(busy), 0);
        step();
        rst = 1'b0;
        evq.delete();
        wait_ev("rg_remake", 1, 200);
        run(60);
        check("rg_remake_count", evq.size(), 1);
        if (evq.size() >= 1) begin
            check("rg_remake_scan", int'(evq[0].scan), 'h2D);
            check("rg_remake_rel",  int'(evq[0].rel), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
